dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters:
  - the core load/store path (cs/wr/mask/addr/data interface, needs a same-cycle answer);
  - an external port (debug loader / DMA) with a valid/ready handshake.
- The core has priority. A starvation counter bounds how long the external port can wait.
- When the external port wins, the block asserts core_stall so the core freezes its PC and register write for that cycle.
- Sits between the load/store unit and the data memory.

Parameters:
- MAX_CORE_RUN, 4, consecutive contended cycles the core may win before the external port is forced through (1..15).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- core_cs  in  1  core memory request
- core_wr  in  1  core write (1) / read (0)
- core_mask  in  4  core byte enables
- core_addr  in  AW  core address
- core_wdata  in  DW  core write data
- core_rdata  out  DW  core read data (combinational from memory)
- core_stall  out  1  core request not served this cycle; core must hold state
- ext_valid  in  1  external request pending
- ext_wr  in  1  external write / read
- ext_mask  in  4  external byte enables
- ext_addr  in  AW  external address
- ext_wdata  in  DW  external write data
- ext_ready  out  1  external request accepted this cycle
- ext_rdata  out  DW  registered external read data
- ext_rvalid  out  1  one-cycle pulse: ext_rdata valid
- mem_cs, mem_wr, mem_mask, mem_addr, mem_wdata  out  1/1/4/AW/DW  memory request
- mem_rdata  in  DW  memory read data (combinational)
- stall_cnt  out  32  saturating count of core_stall cycles

Behaviour:
- Reset (rst=1 at a rising edge):
  - starve_cnt=0, ext_rdata=0, ext_rvalid=0, stall_cnt=0.
  - While rst is high, combinational outputs are forced: mem_cs=0, ext_ready=0, core_stall=0.
- Grant, combinational each cycle:
  - grant_ext = ext_valid & (~core_cs | starve_cnt==MAX_CORE_RUN).
  - grant_core = core_cs & ~grant_ext.
- Outputs from the grant:
  - ext_ready = grant_ext.
  - core_stall = core_cs & grant_ext.
  - mem_* = ext_* when grant_ext; core_* when grant_core; otherwise mem_cs=0 and all other mem_* = 0.
  - core_rdata = mem_rdata always. The core uses it only when core_stall=0.
- starve_cnt, next value:
  - core_cs & ext_valid & grant_core: +1.
  - grant_ext or ~ext_valid: 0.
  - It never exceeds MAX_CORE_RUN.
- External handshake:
  - ext_* must stay stable while ext_valid=1 and ext_ready=0.
  - Dropping ext_valid before ready is a protocol error (no defined behaviour required).
  - Back-to-back requests are allowed.
- External read response:
  - On grant_ext & ~ext_wr: ext_rdata <= mem_rdata and ext_rvalid <= 1 at the next edge, so 1-cycle latency.
  - Otherwise ext_rvalid <= 0 and ext_rdata holds.
- External writes get no response beyond ext_ready.
- stall_cnt increments on every cycle with core_stall=1 and saturates at 0xFFFF_FFFF.
- Worst case: the external port waits MAX_CORE_RUN cycles under continuous core traffic. The core stalls at most 1 cycle per MAX_CORE_RUN+1 contended cycles.
- Simultaneous read and write to the same address by different requesters cannot happen in one cycle (single grant).
- Reset mid-transaction: a pending ext_valid is not accepted while rst=1. A pending ext_rvalid is cleared.

Test Plan:
- Core only: core_cs=1, core_wr=1, addr=0x10, wdata=0xDEADBEEF, mask=0xF; then read 0x10 -> mem_* mirror core, core_stall=0, core_rdata=0xDEADBEEF.
- Ext only: ext write 0x20=0x12345678, then ext read 0x20 -> ext_ready=1 on the same cycle as valid; ext_rvalid=1 one cycle after the read, ext_rdata=0x12345678.
- Contention, MAX_CORE_RUN=4: core_cs=1 and ext_valid=1 held continuously -> core wins 4 cycles; ext_ready=1 and core_stall=1 on the 5th; pattern repeats with period 5; stall_cnt=2 after 10 cycles.
- Counter clear: 2 contended core wins, ext_valid drops for 1 cycle, then contention resumes -> starve_cnt restarts at 0, so ext waits 4 more cycles.
- Reset mid-operation: assert rst during an ext read grant with ext_valid=1 -> no ext_ready while rst=1; ext_rvalid=0, stall_cnt=0 after the edge; the request is served on the first cycle after rst drops.
- Byte mask passthrough: ext write mask=0x3, addr=0x30 -> mem_mask=0x3, mem_addr=0x30, core_stall=0 when core_cs=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the core load/store path has priority, and the external valid/ready
// port is forced through after MAX_CORE_RUN consecutive contended cycles won by the core.
module dmem_arbiter #(
  parameter int unsigned MAX_CORE_RUN = 4,
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          core_cs,
  input  logic          core_wr,
  input  logic [3:0]    core_mask,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,

  input  logic          ext_valid,
  input  logic          ext_wr,
  input  logic [3:0]    ext_mask,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ready,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_rvalid,

  output logic          mem_cs,
  output logic          mem_wr,
  output logic [3:0]    mem_mask,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic [31:0]   stall_cnt
);

  localparam logic [3:0] MAX_RUN = 4'(MAX_CORE_RUN);

  // Consecutive contended cycles the core has won; reaching MAX_RUN hands the next one to ext.
  logic [3:0] starve_cnt;
  logic       grant_ext;
  logic       grant_core;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it
    // unassigned and infer a latch.
    grant_ext  = 1'b0;
    grant_core = 1'b0;
    if (!rst) begin
      grant_ext  = ext_valid && (!core_cs || starve_cnt == MAX_RUN);
      grant_core = core_cs && !grant_ext;
    end
  end

  assign ext_ready  = grant_ext;
  assign core_stall = core_cs && grant_ext;
  assign core_rdata = mem_rdata;

  // Idle cycles drive an all-zero request so the memory sees no stale address or data.
  always_comb begin
    mem_cs    = 1'b0;
    mem_wr    = 1'b0;
    mem_mask  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_ext) begin
      mem_cs    = 1'b1;
      mem_wr    = ext_wr;
      mem_mask  = ext_mask;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else if (grant_core) begin
      mem_cs    = 1'b1;
      mem_wr    = core_wr;
      mem_mask  = core_mask;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      starve_cnt <= '0;
      ext_rdata  <= '0;
      ext_rvalid <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      if (core_cs && ext_valid && grant_core)
        starve_cnt <= starve_cnt + 4'd1;
      else
        starve_cnt <= '0;

      ext_rvalid <= grant_ext && !ext_wr;
      if (grant_ext && !ext_wr)
        ext_rdata <= mem_rdata;

      if (core_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a word-addressed memory, a cycle-level reference model checked on
// every falling edge, and directed scenarios with hand-computed literal expectations.
module tb_dmem_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_cs, core_wr;
  logic [3:0]  core_mask;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        ext_valid, ext_wr;
  logic [3:0]  ext_mask;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_ready;
  logic [31:0] ext_rdata;
  logic        ext_rvalid;
  logic        mem_cs, mem_wr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  dmem_arbiter #(.MAX_CORE_RUN(MAX), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .core_cs(core_cs), .core_wr(core_wr), .core_mask(core_mask), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_valid(ext_valid), .ext_wr(ext_wr), .ext_mask(ext_mask), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ready(ext_ready), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_mask(mem_mask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // The memory the DUT drives.
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk)
    if (mem_cs && mem_wr) mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_wdata, mem_mask);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: contents the memory must hold, how many contended cycles the external
  // port has been waiting, and the expected registered outputs.
  logic [31:0] gold [0:255];
  int          ext_wait = 0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata  = '0;
  logic [31:0] m_stalls = '0;

  always @(negedge clk) begin
    logic ge, gc;
    ge = !rst && ext_valid && (!core_cs || ext_wait == MAX);
    gc = !rst && core_cs && !ge;

    check("mem_cs",     {31'd0, mem_cs},     {31'd0, ge || gc});
    check("mem_wr",     {31'd0, mem_wr},     ge ? {31'd0, ext_wr}   : gc ? {31'd0, core_wr}   : 32'd0);
    check("mem_mask",   {28'd0, mem_mask},   ge ? {28'd0, ext_mask} : gc ? {28'd0, core_mask} : 32'd0);
    check("mem_addr",   mem_addr,            ge ? ext_addr  : gc ? core_addr  : 32'd0);
    check("mem_wdata",  mem_wdata,           ge ? ext_wdata : gc ? core_wdata : 32'd0);
    check("ext_ready",  {31'd0, ext_ready},  {31'd0, ge});
    check("core_stall", {31'd0, core_stall}, {31'd0, core_cs && ge});
    check("ext_rvalid", {31'd0, ext_rvalid}, {31'd0, m_rvalid});
    check("ext_rdata",  ext_rdata,           m_rdata);
    check("stall_cnt",  stall_cnt,           m_stalls);
    if (gc && !core_wr) check("core_rdata", core_rdata, gold[core_addr[9:2]]);

    // State after the coming rising edge; inputs only change just after that edge.
    if (rst) begin
      ext_wait = 0;
      m_rvalid = 1'b0;
      m_rdata  = '0;
      m_stalls = '0;
    end else begin
      m_rvalid = ge && !ext_wr;
      if (ge && !ext_wr) m_rdata = gold[ext_addr[9:2]];
      if (ge && ext_wr)  gold[ext_addr[9:2]]  = merge(gold[ext_addr[9:2]], ext_wdata, ext_mask);
      if (gc && core_wr) gold[core_addr[9:2]] = merge(gold[core_addr[9:2]], core_wdata, core_mask);
      ext_wait = (core_cs && ext_valid && gc) ? ext_wait + 1 : 0;
      if (core_cs && ge && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_cs = 0; core_wr = 0; core_mask = 0; core_addr = 0; core_wdata = 0;
    ext_valid = 0; ext_wr = 0; ext_mask = 0; ext_addr = 0; ext_wdata = 0;
  endtask

  task automatic core_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    core_cs = 1; core_wr = wr; core_mask = 4'hF; core_addr = addr; core_wdata = wdata;
  endtask

  task automatic ext_req(input logic wr, input logic [3:0] m, input logic [31:0] addr,
                         input logic [31:0] wdata);
    ext_valid = 1; ext_wr = wr; ext_mask = m; ext_addr = addr; ext_wdata = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = '0;
      gold[i] = '0;
    end
    idle();
    rst = 1;
    core_req(1'b0, 32'h10, 32'h0);
    ext_req(1'b0, 4'hF, 32'h20, 32'h0);

    // Reset: both requesters pending, nothing may reach memory.
    @(negedge clk);
    check("rst_mem_cs",     {31'd0, mem_cs},     32'd0);
    check("rst_ext_ready",  {31'd0, ext_ready},  32'd0);
    check("rst_core_stall", {31'd0, core_stall}, 32'd0);
    check("rst_stall_cnt",  stall_cnt,           32'd0);
    step();
    rst = 0;
    idle();

    // Core only: write then read back.
    step();
    core_req(1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    check("core_wr_mem_addr", mem_addr, 32'h10);
    check("core_wr_stall", {31'd0, core_stall}, 32'd0);
    step();
    core_req(1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("core_rd_data", core_rdata, 32'hDEADBEEF);

    // External only: write then read, data one cycle after acceptance.
    step();
    idle();
    ext_req(1'b1, 4'hF, 32'h20, 32'h12345678);
    @(negedge clk);
    check("ext_wr_ready", {31'd0, ext_ready}, 32'd1);
    step();
    ext_req(1'b0, 4'hF, 32'h20, 32'h0);
    @(negedge clk);
    check("ext_rd_ready", {31'd0, ext_ready}, 32'd1);
    step();
    idle();
    @(negedge clk);
    check("ext_rvalid_pulse", {31'd0, ext_rvalid}, 32'd1);
    check("ext_rdata_val", ext_rdata, 32'h12345678);
    step();
    @(negedge clk);
    check("ext_rvalid_drop", {31'd0, ext_rvalid}, 32'd0);

    // Continuous contention: external gets every 5th cycle.
    check("pre_contend_stalls", stall_cnt, 32'd0);
    for (int c = 1; c <= 10; c++) begin
      step();
      core_req(1'b0, 32'h10, 32'h0);
      ext_req(1'b0, 4'hF, 32'h20, 32'h0);
      @(negedge clk);
      check("contend_ready", {31'd0, ext_ready}, (c % 5 == 0) ? 32'd1 : 32'd0);
      check("contend_stall", {31'd0, core_stall}, (c % 5 == 0) ? 32'd1 : 32'd0);
    end
    step();
    idle();
    @(negedge clk);
    check("contend_stall_cnt", stall_cnt, 32'd2);

    // Starvation counter clears when ext_valid drops.
    for (int c = 1; c <= 8; c++) begin
      step();
      core_req(1'b0, 32'h10, 32'h0);
      if (c == 3) begin
        ext_valid = 0;
      end else begin
        ext_req(1'b0, 4'hF, 32'h20, 32'h0);
      end
      @(negedge clk);
      check("clear_ready", {31'd0, ext_ready}, (c == 8) ? 32'd1 : 32'd0);
    end

    // Byte-mask passthrough on an external write.
    step();
    idle();
    core_req(1'b1, 32'h30, 32'hAAAAAAAA);
    step();
    idle();
    ext_req(1'b1, 4'h3, 32'h30, 32'h11223344);
    @(negedge clk);
    check("mask_mem_mask", {28'd0, mem_mask}, 32'h3);
    check("mask_mem_addr", mem_addr, 32'h30);
    check("mask_core_stall", {31'd0, core_stall}, 32'd0);
    step();
    ext_req(1'b0, 4'hF, 32'h30, 32'h0);
    step();
    idle();
    @(negedge clk);
    check("mask_readback", ext_rdata, 32'hAAAA3344);

    // Reset in the middle of back-to-back external reads.
    step();
    ext_req(1'b0, 4'hF, 32'h20, 32'h0);
    step();
    rst = 1;
    @(negedge clk);
    check("midrst_ready", {31'd0, ext_ready}, 32'd0);
    check("midrst_mem_cs", {31'd0, mem_cs}, 32'd0);
    check("midrst_rvalid_before", {31'd0, ext_rvalid}, 32'd1);
    step();
    rst = 0;
    @(negedge clk);
    check("midrst_rvalid_cleared", {31'd0, ext_rvalid}, 32'd0);
    check("midrst_stall_cnt", stall_cnt, 32'd0);
    check("midrst_served", {31'd0, ext_ready}, 32'd1);
    step();
    idle();
    @(negedge clk);
    check("midrst_rdata", ext_rdata, 32'h12345678);

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
